// File: rtl/vb_decoder.sv
// Variable-byte stream decoder: rebuilds DATA_W-bit integers from MSB-group-first
// byte streams (bit7 = last byte), flags malformed integers and resyncs on a terminator.
module vb_decoder #(
    parameter int DATA_W    = 32,
    parameter int MAX_BYTES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [7:0]        err_count
);
    localparam int         ACC_W   = 7 * MAX_BYTES;
    localparam logic [2:0] MAX_CNT = 3'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE, S_ERR} state_t;

    state_t            state_q;
    // Only MAX_BYTES-1 groups are ever stored: the final group is folded in on the fly.
    logic [ACC_W-8:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              discard_q;
    logic [DATA_W-1:0] out_data_q;
    logic [2:0]        out_len_q;
    logic              out_valid_q;
    logic              err_q;
    logic [7:0]        err_count_q, err_count_inc;
    logic              in_xfer, is_term, acc_ovf;

    assign in_ready      = (state_q != S_DONE);
    assign in_xfer       = in_valid && in_ready;
    assign is_term       = in_data[7];
    assign acc_d         = {acc_q, in_data[6:0]};
    assign cnt_d         = cnt_q + 3'd1;
    assign acc_ovf       = (acc_d >> DATA_W) != '0;
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (in_xfer) begin
                        if (is_term) begin
                            if (acc_ovf) begin
                                state_q     <= S_ERR;
                                err_q       <= 1'b1;
                                err_count_q <= err_count_inc;
                                discard_q   <= 1'b0;
                                acc_q       <= '0;
                                cnt_q       <= '0;
                            end else begin
                                state_q     <= S_DONE;
                                out_valid_q <= 1'b1;
                                out_data_q  <= acc_d[DATA_W-1:0];
                                out_len_q   <= cnt_d;
                            end
                        end else if (cnt_d == MAX_CNT) begin
                            // Too long: drop everything up to and including the next terminator.
                            state_q     <= S_ERR;
                            err_q       <= 1'b1;
                            err_count_q <= err_count_inc;
                            discard_q   <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                        end else begin
                            state_q <= S_ACCUM;
                            acc_q   <= acc_d[ACC_W-8:0];
                            cnt_q   <= cnt_d;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                S_ERR: begin
                    if (!discard_q || (in_xfer && is_term)) begin
                        state_q   <= S_IDLE;
                        err_q     <= 1'b0;
                        discard_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_vb_decoder.sv
// Bench for vb_decoder: directed vector table, hand-written reset/back-pressure
// sequences, then random integer streams scored against an encoding-level model.
module tb_vb_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_len;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err;
    logic [7:0]  err_count;

    vb_decoder #(.DATA_W(32), .MAX_BYTES(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_len(out_len), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit rnd_mode = 1'b0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          n;
        logic [63:0] bytes;     // first byte in the most significant used position
        int          kind;      // 0 = good, 1 = overflow, 2 = too long
        logic [31:0] exp_data;
        logic [2:0]  exp_len;
        int          exp_errs;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  l;
    } res_t;

    vec_t tbl[10];
    res_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!done) begin
            n_checks++;
            $display("FAIL send_byte: in_ready stuck at 0 for byte 0x%02h", b);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] d, input logic [2:0] l);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(out_data), 64'(d));
        check({name, "_len"}, 64'(out_len), 64'(l));
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rnd_result: unexpected result 0x%0h len %0d", out_data, out_len);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("rnd_result", {29'd0, out_len, out_data}, {29'd0, e.l, e.d});
            end
        end
    end

    initial begin
        logic [7:0] q[$];
        logic [63:0] v;
        int len, exp_errs;

        tbl[0] = '{1, 64'h85,               0, 32'h5,        3'd1, 0};
        tbl[1] = '{2, 64'h06B8,             0, 32'h338,      3'd2, 0};
        tbl[2] = '{5, 64'h0F7F7F7FFF,       0, 32'hFFFFFFFF, 3'd5, 0};
        tbl[3] = '{5, 64'h1000000080,       1, 32'h0,        3'd0, 1};
        tbl[4] = '{1, 64'h81,               0, 32'h1,        3'd1, 1};
        tbl[5] = '{8, 64'h00000000007F7F81, 2, 32'h0,        3'd0, 2};
        tbl[6] = '{1, 64'h82,               0, 32'h2,        3'd1, 2};
        tbl[7] = '{3, 64'h000081,           0, 32'h1,        3'd3, 2};
        tbl[8] = '{5, 64'h000000008F,       0, 32'hF,        3'd5, 2};
        tbl[9] = '{4, 64'h7F7F7FFF,         0, 32'h0FFFFFFF, 3'd4, 2};

        // Power-on reset
        tick();
        tick();
        @(negedge clk);
        check("por_out_valid", 64'(out_valid), 64'd0);
        check("por_err", 64'(err), 64'd0);
        check("por_err_count", 64'(err_count), 64'd0);
        check("por_in_ready", 64'(in_ready), 64'd1);
        check("por_out_len", 64'(out_len), 64'd0);
        tick();
        rst_n = 1'b1;

        // Directed vector table
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                send_byte(tbl[t].bytes[8*(tbl[t].n-1-i) +: 8]);
                if (tbl[t].kind == 2 && i == 4) begin
                    @(negedge clk);
                    check($sformatf("vec%0d_toolong_err_rise", t), 64'(err), 64'd1);
                    tick();
                end
            end
            case (tbl[t].kind)
                0: expect_result($sformatf("vec%0d", t), tbl[t].exp_data, tbl[t].exp_len);
                1: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_ovf_err", t), 64'(err), 64'd1);
                    check($sformatf("vec%0d_ovf_no_out", t), 64'(out_valid), 64'd0);
                    check($sformatf("vec%0d_err_count", t), 64'(err_count), 64'(tbl[t].exp_errs));
                    tick();
                    @(negedge clk);
                    check($sformatf("vec%0d_ovf_err_one_cycle", t), 64'(err), 64'd0);
                    tick();
                end
                default: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_toolong_err_drop", t), 64'(err), 64'd0);
                    check($sformatf("vec%0d_toolong_no_out", t), 64'(out_valid), 64'd0);
                    check($sformatf("vec%0d_err_count", t), 64'(err_count), 64'(tbl[t].exp_errs));
                    tick();
                end
            endcase
        end

        // Reset from mid-ACCUM with a nonzero error count
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        send_byte(8'h85);
        expect_result("post_rst", 32'd5, 3'd1);

        // Back-pressure: result held while the next byte waits
        send_byte(8'h83);
        in_data   = 8'h84;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_xfer_valid", 64'(out_valid), 64'd0);
        check("bp_after_xfer_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        expect_result("bp_next", 32'd4, 3'd1);

        // Random integer streams against the encoding-level model
        exp_errs = 0;
        rnd_mode = 1'b1;
        mon_en   = 1'b1;
        for (int u = 0; u < 200; u++) begin
            int r;
            q.delete();
            r = $urandom_range(0, 9);
            if (r < 6) begin
                len = $urandom_range(1, 5);
                v = 64'($urandom);
                if (r == 0) v = 64'($urandom_range(0, 3));
                v = v & ((64'd1 << (7 * len)) - 64'd1);
                for (int i = len - 1; i >= 0; i--)
                    q.push_back(8'((v >> (7 * i)) & 64'h7F) | ((i == 0) ? 8'h80 : 8'h00));
                exp_q.push_back('{v[31:0], 3'(len)});
            end else if (r < 8) begin
                q.push_back(8'($urandom_range(16, 127)));
                for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 127)));
                q.push_back(8'($urandom_range(128, 255)));
                exp_errs++;
            end else begin
                len = $urandom_range(6, 9);
                for (int i = 0; i < len - 1; i++) q.push_back(8'($urandom_range(0, 127)));
                q.push_back(8'($urandom_range(128, 255)));
                exp_errs++;
            end
            foreach (q[i]) begin
                if ($urandom_range(0, 3) == 0) idle();
                send_byte(q[i]);
            end
            idle();
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        check("rnd_drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("rnd_err_count", 64'(err_count), 64'((exp_errs > 255) ? 255 : exp_errs));
        check("rnd_final_err", 64'(err), 64'd0);
        check("rnd_final_valid", 64'(out_valid), 64'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vb_decoder.md
Name: vb_decoder

Overview:
Variable-byte (VB) stream decoder. It sits directly downstream of the VB encoder and rebuilds the 32-bit unsigned integer from the encoder's byte stream.
- Bytes arrive most-significant 7-bit group first.
- bit7=1 marks the terminating (last) byte of an integer; bit7=0 means more bytes follow.
- The decoded integer is presented on a valid/ready output with its byte length. Malformed streams are flagged and counted, and the block resynchronises on the next terminator.

Parameters:
DATA_W, 32, width of decoded integer.
MAX_BYTES, 5, maximum bytes per integer; must equal ceil(DATA_W/7).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  synchronous active-low reset.
in_data  input  8  stream byte; [7] terminator flag, [6:0] payload group.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  decoder accepts a byte this cycle.
out_data  output  DATA_W  decoded integer.
out_len  output  3  number of bytes that formed out_data (1..MAX_BYTES).
out_valid  output  1  out_data/out_len valid.
out_ready  input  1  consumer takes the result.
err  output  1  high while in ERR state.
err_count  output  8  saturating count of malformed integers.

Behaviour:
- Reset is synchronous: a rising edge with rst_n=0 sets state=IDLE.
  - All registered outputs and internals go to 0: out_data=0, out_len=0, out_valid=0, err=0, err_count=0, accumulator=0, byte counter=0.
  - Reset applies in any state; a partial integer or an unconsumed result is discarded.
- Byte transfer occurs on an edge with in_valid=1, in_ready=1, and rst_n=1.
- Output transfer occurs on an edge with out_valid=1 and out_ready=1.
- in_ready is combinational from state: 1 in IDLE, ACCUM and ERR; 0 in DONE.
  - in_ready is 1 during reset, but transfers are ignored while rst_n=0.
- Accumulator is 7*MAX_BYTES bits (35). Per accepted byte: acc_next = (acc<<7) | in_data[6:0]; cnt_next = cnt+1.
- States and transitions:
  - IDLE (acc=0, cnt=0). Accepted byte with bit7=1 goes to DONE. Accepted byte with bit7=0 goes to ACCUM.
  - ACCUM. Accepted byte with bit7=1 goes to DONE if acc_next[34:DATA_W]==0; otherwise ERR (overflow, terminator consumed).
  - ACCUM, bit7=0 case. If cnt_next<MAX_BYTES, stay in ACCUM. If cnt_next==MAX_BYTES, go to ERR in discard mode (sequence too long).
  - DONE. out_valid=1, out_data=acc[DATA_W-1:0], out_len=cnt. Holds all outputs stable until the output transfer, then goes to IDLE with acc and cnt cleared. No bytes are accepted in DONE.
  - ERR. err=1; err_count is incremented (saturating at 255) on entry.
    - After an overflow, ERR lasts exactly one cycle, then IDLE.
    - In discard mode, accepted bytes are dropped until a byte with bit7=1 is accepted; the next state is then IDLE.
  - DONE and ERR are both entered one cycle after the decisive edge.
- Overflow applies on the terminator only, not on non-terminator bytes: bits above DATA_W-1 nonzero, i.e. first payload of a 5-byte integer >0x0F.
- Latency: the terminator is accepted at edge N; out_valid=1 after edge N. Minimum throughput is one integer per (len+1) cycles.
- Leading 0x00 groups (non-canonical) are accepted. The value is unaffected but they count toward out_len and the MAX_BYTES limit.
- out_valid falls after the output-transfer edge. out_data/out_len retain their last values while out_valid=0.
- in_data is ignored whenever in_ready=0 or in_valid=0.

Test Plan:
- Reset: hold rst_n=0 for 2 edges from arbitrary state (mid-ACCUM with bytes 0x01,0x02 sent) -> out_valid=0, out_data=0, out_len=0, err=0, err_count=0, in_ready=1. Then 0x85 -> out_data=5, out_len=1.
- Single/multi-byte: 0x85 -> out_valid high the next cycle with out_data=0x5, out_len=1. Then 0x06,0xB8 -> out_data=0x338 (824), out_len=2.
- Maximum value: 0x0F,0x7F,0x7F,0x7F,0xFF -> out_data=0xFFFFFFFF, out_len=5.
- Overflow: 0x10,0x00,0x00,0x00,0x80 -> no out_valid; err=1 for exactly one cycle; err_count=1. Next 0x81 -> out_data=1, out_len=1.
- Too long: 0x00 x5 -> err=1 after the 5th byte. Then 0x7F,0x7F,0x81 are consumed with no output; err drops after 0x81. Next 0x82 -> out_data=2; err_count=2.
- Back-pressure: 0x83 decoded, out_ready=0 for 3 cycles while in_valid=1 with in_data=0x84 -> in_ready=0, out_data=3 stable. On out_ready=1 the result transfers; next cycle 0x84 is accepted, then out_data=4.
